// File: rtl/sinrcv_pkg.sv
// ---------------------------------------------------------------------------
// sinrcv_pkg
// Shared types and constants for the sinrcv write-interface responder.
//   state_t    : transfer FSM states
//   lane_t     : byte-lane counter within a 32-bit word
//   SINRCV_BASE_ADDR : default base of the decoded address window
//   LANES / LAST_LANE : number of byte lanes per word and the final lane index
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

package sinrcv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR   = 2'd1,
        ACK  = 2'd2,
        REL  = 2'd3
    } state_t;

    typedef logic [1:0] lane_t;

    localparam logic [31:0] SINRCV_BASE_ADDR = 32'hA000_0000;
    localparam int          LANES            = 4;
    localparam lane_t       LAST_LANE        = lane_t'(LANES - 1);

endpackage

// File: rtl/sinrcv_ram.sv
// ---------------------------------------------------------------------------
// sinrcv_ram
// 2**ADDR_W x 8 simple dual-port sample buffer.
//   clk      : clock, rising edge
//   reset    : synchronous active-high, clears only the read-port registers
//   wr_en    : write strobe for one byte
//   wr_addr  : write byte address
//   wr_data  : write byte
//   rd_en    : read request
//   rd_addr  : read byte address
//   rd_data  : registered read byte (one-cycle latency)
//   rd_valid : registered read-valid pulse
// The array itself is never reset. A read and write to the same address in
// the same cycle returns the value held before the write.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module sinrcv_ram
    import sinrcv_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [7:0]        wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [7:0]        rd_data,
    output logic              rd_valid
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read stage: the non-blocking read of mem sees the pre-write contents,
    // giving read-old-data behaviour on a same-address collision.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) begin
                rd_data <= mem[rd_addr];
            end
        end
    end

endmodule

// File: rtl/sinrcv.sv
// ---------------------------------------------------------------------------
// sinrcv
// Responder end of the mdriver_int write interface. Word writes that fall in
// the 2**ADDR_W-byte window at BASE_ADDR are stored little-endian into a byte
// buffer, one lane per cycle; every transfer is acknowledged with a one-cycle
// fin pulse. Writes outside the window set a sticky err flag.
//   clk        : clock, rising edge
//   reset      : synchronous, active-high
//   exec       : transfer request, level, held until fin is seen
//   we         : write enable qualifying exec
//   si_address : byte address of transfer
//   si_data    : write word, byte 0 in [7:0]
//   fin        : one-cycle transfer-complete pulse
//   busy       : high whenever the FSM is not idle
//   rd_en      : read-back request
//   rd_addr    : read-back byte address
//   rd_data    : read-back byte, one cycle after rd_en
//   rd_valid   : high one cycle after rd_en
//   wr_count   : completed in-window writes, saturating
//   err        : sticky out-of-window write flag
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module sinrcv
    import sinrcv_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = SINRCV_BASE_ADDR,
    parameter int          ADDR_W    = 8,
    parameter int          CNT_W     = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              exec,
    input  logic              we,
    input  logic [31:0]       si_address,
    input  logic [31:0]       si_data,
    output logic              fin,
    output logic              busy,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [7:0]        rd_data,
    output logic              rd_valid,
    output logic [CNT_W-1:0]  wr_count,
    output logic              err
);

    state_t            state;
    lane_t             lane;
    logic              xfer_ok;
    logic [ADDR_W-1:0] xfer_addr;
    logic [31:0]       xfer_data;
    logic              hit;

    logic              ram_wr_en;
    logic [ADDR_W-1:0] ram_wr_addr;
    logic [7:0]        ram_wr_data;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] r;
        r = v;
        if (v != '1) begin
            r = v + 1'b1;
        end
        return r;
    endfunction

    function automatic logic [7:0] lane_byte(input logic [31:0] w, input lane_t k);
        logic [7:0] b;
        case (k)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        return b;
    endfunction

    assign hit = (si_address[31:ADDR_W] == BASE_ADDR[31:ADDR_W]);

    // Capture stage: address/data are frozen at acceptance so later changes
    // on the bus during WR/ACK/REL have no effect.
    always_ff @(posedge clk) begin
        if (state == IDLE && exec) begin
            xfer_addr <= si_address[ADDR_W-1:0];
            xfer_data <= si_data;
        end
    end

    // Lane write stage: reset suppresses the lane that would otherwise land
    // in the same cycle, so an aborted transfer leaves only completed lanes.
    // The address add wraps naturally inside ADDR_W bits.
    assign ram_wr_en   = (state == WR) && !reset;
    assign ram_wr_addr = xfer_addr + ADDR_W'(lane);
    assign ram_wr_data = lane_byte(xfer_data, lane);

    // Control stage: fin and busy are registered from the next-state decision
    // so that fin coincides with the ACK cycle and busy tracks non-IDLE.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            lane     <= '0;
            xfer_ok  <= 1'b0;
            fin      <= 1'b0;
            busy     <= 1'b0;
            wr_count <= '0;
            err      <= 1'b0;
        end else begin
            fin <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (exec) begin
                        busy <= 1'b1;
                        lane <= '0;
                        if (we && hit) begin
                            state   <= WR;
                            xfer_ok <= 1'b1;
                        end else begin
                            state   <= ACK;
                            xfer_ok <= 1'b0;
                            fin     <= 1'b1;
                            if (we) begin
                                err <= 1'b1;
                            end
                        end
                    end
                end
                WR: begin
                    lane <= lane + 1'b1;
                    if (lane == LAST_LANE) begin
                        state <= ACK;
                        fin   <= 1'b1;
                    end
                end
                ACK: begin
                    if (xfer_ok) begin
                        wr_count <= sat_inc(wr_count);
                    end
                    if (exec) begin
                        state <= REL;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                REL: begin
                    if (!exec) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    sinrcv_ram #(
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (ram_wr_en),
        .wr_addr  (ram_wr_addr),
        .wr_data  (ram_wr_data),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_valid (rd_valid)
    );

endmodule

// File: tb/tb_sinrcv.sv
// ---------------------------------------------------------------------------
// tb_sinrcv
// Self-checking bench for sinrcv: a table of word transfers with expected
// latency / err / wr_count, hand-written multi-cycle sequences, and a random
// phase compared against a byte-array reference model of the buffer.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_sinrcv;

    logic        clk = 1'b0;
    logic        reset;
    logic        exec;
    logic        we;
    logic [31:0] si_address;
    logic [31:0] si_data;
    logic        fin;
    logic        busy;
    logic        rd_en;
    logic [7:0]  rd_addr;
    logic [7:0]  rd_data;
    logic        rd_valid;
    logic [15:0] wr_count;
    logic        err;

    int checks = 0;
    int errors = 0;

    // Reference model: buffer bytes, which bytes are known, counter, err.
    logic [7:0] mem_m   [256];
    bit         known_m [256];
    int         cnt_m;
    bit         err_m;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic        we;
        int          exp_lat;
        logic        exp_err;
        logic [15:0] exp_cnt;
    } vec_t;

    localparam int NV = 8;
    vec_t tbl [NV];

    always #5 clk = ~clk;

    sinrcv dut (
        .clk        (clk),
        .reset      (reset),
        .exec       (exec),
        .we         (we),
        .si_address (si_address),
        .si_data    (si_data),
        .fin        (fin),
        .busy       (busy),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .wr_count   (wr_count),
        .err        (err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic bit in_win(input logic [31:0] a);
        return a[31:8] == 24'hA00000;
    endfunction

    task automatic model_xfer(input logic [31:0] a, input logic [31:0] d, input logic w);
        if (w && in_win(a)) begin
            for (int k = 0; k < 4; k++) begin
                logic [7:0] ix;
                ix = a[7:0] + 8'(k);
                mem_m[ix]   = d[8*k +: 8];
                known_m[ix] = 1'b1;
            end
            if (cnt_m < 65535) cnt_m++;
        end else if (w) begin
            err_m = 1'b1;
        end
    endtask

    // Full transfer: returns cycles from exec acceptance to fin (-1 on timeout).
    task automatic xfer(input logic [31:0] a, input logic [31:0] d, input logic w, output int lat);
        exec = 1'b1; we = w; si_address = a; si_data = d;
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (fin === 1'b1) begin
                lat = i;
                break;
            end
        end
        exec = 1'b0; we = 1'b0;
        si_address = $urandom; si_data = $urandom;
        if (lat < 0) begin
            checks++; errors++;
            $display("FAIL xfer_timeout: no fin for addr %h", a);
        end
        model_xfer(a, d, w);
        tick();
        chk("fin_single", fin, 1'b0);
        chk("busy_after", busy, 1'b0);
    endtask

    task automatic rd(input logic [7:0] a, input logic [7:0] exp, input string name);
        rd_en = 1'b1; rd_addr = a;
        tick();
        rd_en = 1'b0;
        chk({name, "_valid"}, rd_valid, 1'b1);
        chk(name, rd_data, exp);
        tick();
        chk({name, "_vpulse"}, rd_valid, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int exp_lat;
        logic [31:0] a, d;
        logic w;

        tbl[0] = '{32'hA000_0010, 32'h4433_2211, 1'b1, 5, 1'b0, 16'd1};
        tbl[1] = '{32'hA000_00FE, 32'hDDCC_BBAA, 1'b1, 5, 1'b0, 16'd2};
        tbl[2] = '{32'hA000_0030, 32'h0000_0000, 1'b1, 5, 1'b0, 16'd3};
        tbl[3] = '{32'hA000_0020, 32'h9988_7766, 1'b1, 5, 1'b0, 16'd4};
        tbl[4] = '{32'hA000_0040, 32'h1234_5678, 1'b0, 1, 1'b0, 16'd4};
        tbl[5] = '{32'hB000_0000, 32'hCAFE_F00D, 1'b1, 1, 1'b1, 16'd4};
        tbl[6] = '{32'hA000_0050, 32'h0BAD_BEEF, 1'b1, 5, 1'b1, 16'd5};
        tbl[7] = '{32'hA000_0100, 32'h1111_1111, 1'b1, 1, 1'b1, 16'd5};

        for (int i = 0; i < 256; i++) begin
            known_m[i] = 1'b0;
            mem_m[i]   = 8'h00;
        end
        cnt_m = 0; err_m = 1'b0;

        reset = 1'b1; exec = 1'b0; we = 1'b0; rd_en = 1'b0; rd_addr = 8'h00;
        si_address = 32'h0; si_data = 32'h0;
        tick(); tick();
        chk("rst_fin", fin, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_rd_valid", rd_valid, 1'b0);
        chk("rst_rd_data", rd_data, 8'h00);
        chk("rst_wr_count", wr_count, 16'd0);
        chk("rst_err", err, 1'b0);
        reset = 1'b0;
        tick();

        // Table-driven transfers.
        for (int i = 0; i < NV; i++) begin
            xfer(tbl[i].addr, tbl[i].data, tbl[i].we, lat);
            chk($sformatf("v%0d_lat", i), lat, tbl[i].exp_lat);
            chk($sformatf("v%0d_err", i), err, tbl[i].exp_err);
            chk($sformatf("v%0d_cnt", i), wr_count, tbl[i].exp_cnt);
        end
        rd(8'h10, 8'h11, "rb10");
        rd(8'h11, 8'h22, "rb11");
        rd(8'h12, 8'h33, "rb12");
        rd(8'h13, 8'h44, "rb13");
        rd(8'hFE, 8'hAA, "rbFE");
        rd(8'hFF, 8'hBB, "rbFF");
        rd(8'h00, 8'hCC, "rb00");
        rd(8'h01, 8'hDD, "rb01");

        // Read collides with lane 0 write at 0x30.
        exec = 1'b1; we = 1'b1; si_address = 32'hA000_0030; si_data = 32'h0000_005A;
        tick();
        chk("col_busy", busy, 1'b1);
        si_address = 32'hA000_0077; si_data = 32'hFFFF_FFFF;
        rd_en = 1'b1; rd_addr = 8'h30;
        tick();
        rd_en = 1'b0;
        chk("col_old_valid", rd_valid, 1'b1);
        chk("col_old_data", rd_data, 8'h00);
        tick();
        chk("col_vpulse", rd_valid, 1'b0);
        lat = -1;
        for (int i = 4; i <= 20; i++) begin
            tick();
            if (fin === 1'b1) begin
                lat = i;
                break;
            end
        end
        exec = 1'b0; we = 1'b0;
        chk("col_lat", lat, 5);
        model_xfer(32'hA000_0030, 32'h0000_005A, 1'b1);
        tick();
        rd(8'h30, 8'h5A, "col_new");
        rd(8'h31, 8'h00, "col_new31");

        // exec held high well past fin.
        exec = 1'b1; we = 1'b1; si_address = 32'hA000_0060; si_data = 32'h8765_4321;
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (fin === 1'b1) begin
                lat = i;
                break;
            end
        end
        chk("hold_lat", lat, 5);
        model_xfer(32'hA000_0060, 32'h8765_4321, 1'b1);
        for (int j = 0; j < 10; j++) begin
            tick();
            chk($sformatf("hold_fin%0d", j), fin, 1'b0);
            chk($sformatf("hold_busy%0d", j), busy, 1'b1);
        end
        exec = 1'b0; we = 1'b0;
        chk("hold_busy_fall", busy, 1'b1);
        tick();
        chk("hold_busy_idle", busy, 1'b0);
        chk("hold_cnt", wr_count, 16'(cnt_m));
        xfer(32'hA000_0064, 32'h0F0E_0D0C, 1'b1, lat);
        chk("hold_next_lat", lat, 5);
        chk("hold_next_cnt", wr_count, 16'(cnt_m));
        rd(8'h63, 8'h87, "hold_rb63");
        rd(8'h64, 8'h0C, "hold_rb64");

        // Reset during WR lane 2.
        exec = 1'b1; we = 1'b1; si_address = 32'hA000_0020; si_data = 32'h4433_2211;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("abort_fin%0d", i), fin, 1'b0);
        end
        reset = 1'b1; exec = 1'b0; we = 1'b0;
        tick();
        reset = 1'b0;
        mem_m[8'h20] = 8'h11;
        mem_m[8'h21] = 8'h22;
        cnt_m = 0; err_m = 1'b0;
        chk("abort_fin", fin, 1'b0);
        chk("abort_busy", busy, 1'b0);
        chk("abort_cnt", wr_count, 16'd0);
        chk("abort_err", err, 1'b0);
        tick();
        chk("abort_fin_late", fin, 1'b0);
        rd(8'h20, 8'h11, "abort_rb20");
        rd(8'h21, 8'h22, "abort_rb21");
        rd(8'h22, 8'h88, "abort_rb22");
        rd(8'h23, 8'h99, "abort_rb23");

        // Random transfers against the reference model.
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 3) == 0) a = $urandom;
            else                           a = {24'hA00000, 8'($urandom)};
            d = $urandom;
            w = ($urandom_range(0, 4) != 0);
            exp_lat = (w && in_win(a)) ? 5 : 1;
            xfer(a, d, w, lat);
            chk($sformatf("rnd%0d_lat", n), lat, exp_lat);
        end
        chk("rnd_cnt", wr_count, 16'(cnt_m));
        chk("rnd_err", err, 32'(err_m));
        for (int i = 0; i < 256; i++) begin
            if (known_m[i]) begin
                rd(8'(i), mem_m[i], $sformatf("rnd_rb%02h", i));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sinrcv.md
Name: sinrcv

Overview:
- Responder (slave) end of the mdriver_int write interface.
- Accepts word writes issued by the sine/ADC driver and decodes the 0xA0000000 window.
- Stores each 32-bit word little-endian into a 256-byte sample buffer and returns fin per transfer.
- Provides a registered byte read-back port, a valid-write counter and a sticky error flag for checker logic downstream.

Parameters:
BASE_ADDR, 32'hA0000000, base of the decoded window.
ADDR_W, 8, log2 of buffer depth in bytes; window size is 2**ADDR_W.
CNT_W, 16, width of wr_count.

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-high
exec  in  1  transfer request from driver; level, held until fin seen
we  in  1  write enable qualifying exec
si_address  in  32  byte address of transfer
si_data  in  32  write word, byte 0 in [7:0]
fin  out  1  one-cycle transfer-complete pulse
busy  out  1  high in any state other than IDLE
rd_en  in  1  read-back request
rd_addr  in  ADDR_W  read-back byte address
rd_data  out  8  read-back byte
rd_valid  out  1  high one cycle after rd_en
wr_count  out  CNT_W  number of completed in-window writes, saturating
err  out  1  sticky: an out-of-window write was seen

Behaviour:
- Reset (sync): state=IDLE; fin=0, busy=0, rd_valid=0, rd_data=0, wr_count=0, err=0. Buffer contents are not cleared.
- States and transitions:
  - IDLE: on exec=1, capture si_address and si_data.
    - we=1 and si_address[31:ADDR_W]==BASE_ADDR[31:ADDR_W]: go to WR with lane=0.
    - Otherwise: go to ACK. If we=1, set err=1; we=0 is a no-op and does not set err.
  - WR: write byte lane k (data[8k+7:8k]) to buffer[(addr[ADDR_W-1:0]+k) mod 2**ADDR_W], one lane per cycle, k=0..3. After lane 3, go to ACK.
  - ACK: fin=1 for exactly this cycle. If the transfer was a valid write, wr_count+=1, saturating at all-ones. Then go to IDLE if exec=0, else REL.
  - REL: wait for exec=0, then go to IDLE. A held-high exec never produces a second transfer.
- Latency: exec sampled in cycle T.
  - Valid write: lanes written T+1..T+4, fin high T+5.
  - Invalid or we=0: fin high T+1.
- Unaligned addresses are allowed; lane addresses wrap modulo 256 (0xFE wraps to 0x00).
- Read port is independent of the write FSM (dual-port buffer).
  - rd_data and rd_valid are registered, one-cycle latency.
  - A read of a byte written in the same cycle returns the old value.
- Reset mid-transfer: FSM returns to IDLE and fin is not issued. Lanes already written stay written; the pending lane is not written. wr_count is cleared.
- si_address and si_data are only sampled in IDLE; changes during WR/ACK/REL are ignored.
- busy=1 in WR, ACK and REL.

Decomposition:
- Package sinrcv_pkg:
  - state enum {IDLE, WR, ACK, REL}
  - BASE_ADDR default constant
  - LANES=4 constant
  - lane counter type logic[1:0]
- Sub-module sinrcv_ram: 2**ADDR_W x 8 simple dual-port RAM, one synchronous write port and one registered read port. No reset on the array.

Test Plan:
- Write 0x44332211 to 0xA0000010, then read 0x10..0x13 -> fin exactly at T+5; bytes 0x11,0x22,0x33,0x44; wr_count=1; err=0.
- Write 0xDDCCBBAA to 0xA00000FE -> buffer[0xFE]=0xAA, [0xFF]=0xBB, [0x00]=0xCC, [0x01]=0xDD; wr_count increments by 1.
- exec with 0xB0000000, we=1 -> fin at T+1; err=1 and stays 1 after further valid writes; wr_count and buffer unchanged.
- Valid write with exec held high 10 cycles after fin -> one fin, wr_count +1 only, busy=1 until the cycle after exec falls; the next exec is accepted normally.
- Assert reset for one cycle while in WR lane 2, with data 0x44332211 to 0xA0000020 -> no fin; [0x20]=0x11, [0x21]=0x22; [0x22],[0x23] unchanged; wr_count=0; busy=0 next cycle.
- rd_en on 0x30 in the same cycle lane 0 writes 0x5A there (old value 0x00) -> rd_data=0x00 next cycle; a repeat read returns 0x5A; rd_valid is a one-cycle pulse each time.
